// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter_if : CPU, DMA and memory-side signal bundle for the arbiter
// Revision: 1.0
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_read_i;
    logic              cpu_write_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic [DATA_W-1:0] cpu_wdata_i;
    logic [DATA_W-1:0] cpu_rdata_o;
    logic              cpu_stall_o;

    logic              dma_req_i;
    logic              dma_we_i;
    logic [ADDR_W-1:0] dma_addr_i;
    logic [DATA_W-1:0] dma_wdata_i;
    logic              dma_gnt_o;
    logic              dma_done_o;
    logic [DATA_W-1:0] dma_rdata_o;

    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_read_o;
    logic              mem_write_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ready_i;

    logic              err_o;

    // Arbiter side: owns the memory port, serves the CPU and DMA requesters
    modport master (
        input  cpu_read_i, cpu_write_i, cpu_addr_i, cpu_wdata_i,
        output cpu_rdata_o, cpu_stall_o,
        input  dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i,
        output dma_gnt_o, dma_done_o, dma_rdata_o,
        output mem_addr_o, mem_read_o, mem_write_o, mem_wdata_o,
        input  mem_rdata_i, mem_ready_i,
        output err_o
    );

    modport slave (
        output cpu_read_i, cpu_write_i, cpu_addr_i, cpu_wdata_i,
        input  cpu_rdata_o, cpu_stall_o,
        output dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i,
        input  dma_gnt_o, dma_done_o, dma_rdata_o,
        input  mem_addr_o, mem_read_o, mem_write_o, mem_wdata_o,
        output mem_rdata_i, mem_ready_i,
        input  err_o
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one memory port between the CPU data port and a
// DMA/debug requester, with wait-state timeout. Optional ARB_DMA_STARVE_EN
// forces a DMA grant after STARVE_LIMIT CPU grants with DMA waiting.
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int WAIT_LIMIT   = 15,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    mem_port_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_ACC  = 2'd1,
        DMA_ACC  = 2'd2,
        DMA_DONE = 2'd3
    } state_t;

    localparam int         c_WAIT_W     = 8;
    localparam logic [7:0] c_WAIT_LIMIT = 8'(WAIT_LIMIT);

    if (WAIT_LIMIT < 1 || WAIT_LIMIT > 255 || STARVE_LIMIT < 1) begin : g_param_check
        $error("mem_port_arbiter: WAIT_LIMIT must be 1..255 and STARVE_LIMIT >= 1");
    end

    state_t              r_state;
    state_t              w_next_state;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_we;
    logic [DATA_W-1:0]   r_cpu_rdata;
    logic [DATA_W-1:0]   r_dma_rdata;

    logic w_cpu_req;
    logic w_in_access;
    logic w_timeout;
    logic w_grant_cpu;
    logic w_grant_dma;
    logic w_force_dma;

    assign w_cpu_req   = bus.cpu_read_i | bus.cpu_write_i;
    assign w_in_access = (r_state == CPU_ACC) || (r_state == DMA_ACC);

`ifdef ARB_DMA_STARVE_EN
    localparam int                  c_STARVE_W     = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_LIMIT = c_STARVE_W'(STARVE_LIMIT);

    logic [c_STARVE_W-1:0] r_starve_cnt;

    assign w_force_dma = bus.dma_req_i && (r_starve_cnt == c_STARVE_LIMIT);

    // Counts CPU grants that left a pending DMA request waiting
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_starve_cnt <= '0;
        end else if (w_grant_dma) begin
            r_starve_cnt <= '0;
        end else if (w_grant_cpu && bus.dma_req_i && (r_starve_cnt != c_STARVE_LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end
`else
    assign w_force_dma = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_grant_cpu  = 1'b0;
        w_grant_dma  = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cpu_req && !w_force_dma) begin
                    w_grant_cpu  = 1'b1;
                    w_next_state = CPU_ACC;
                end else if (bus.dma_req_i) begin
                    w_grant_dma  = 1'b1;
                    w_next_state = DMA_ACC;
                end
            end
            CPU_ACC: begin
                if (bus.mem_ready_i) begin
                    w_next_state = IDLE;
                end else if (r_wait_cnt == c_WAIT_LIMIT) begin
                    w_timeout    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            DMA_ACC: begin
                // An aborted DMA access still finishes through DMA_DONE
                if (bus.mem_ready_i) begin
                    w_next_state = DMA_DONE;
                end else if (r_wait_cnt == c_WAIT_LIMIT) begin
                    w_timeout    = 1'b1;
                    w_next_state = DMA_DONE;
                end
            end
            DMA_DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wait_cnt  <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
        end else begin
            if (w_grant_cpu) begin
                r_addr     <= bus.cpu_addr_i;
                r_wdata    <= bus.cpu_wdata_i;
                r_we       <= bus.cpu_write_i;
                r_wait_cnt <= '0;
            end else if (w_grant_dma) begin
                r_addr     <= bus.dma_addr_i;
                r_wdata    <= bus.dma_wdata_i;
                r_we       <= bus.dma_we_i;
                r_wait_cnt <= '0;
            end else if (w_in_access && !bus.mem_ready_i && !w_timeout) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            if ((r_state == CPU_ACC) && bus.mem_ready_i && !r_we) begin
                r_cpu_rdata <= bus.mem_rdata_i;
            end
            if ((r_state == DMA_ACC) && bus.mem_ready_i && !r_we) begin
                r_dma_rdata <= bus.mem_rdata_i;
            end
        end
    end

    // Stall releases in the cycle the CPU access completes or is abandoned
    assign bus.cpu_stall_o = w_cpu_req &&
                             !((r_state == CPU_ACC) && (bus.mem_ready_i || w_timeout));
    assign bus.cpu_rdata_o = ((r_state == CPU_ACC) && bus.mem_ready_i) ? bus.mem_rdata_i
                                                                       : r_cpu_rdata;

    assign bus.dma_gnt_o   = (r_state == DMA_ACC);
    assign bus.dma_done_o  = (r_state == DMA_DONE);
    assign bus.dma_rdata_o = r_dma_rdata;

    assign bus.mem_addr_o  = r_addr;
    assign bus.mem_wdata_o = r_wdata;
    assign bus.mem_read_o  = w_in_access && !r_we;
    assign bus.mem_write_o = w_in_access && r_we;

    assign bus.err_o       = w_timeout && !rst_i;

endmodule
`default_nettype wire
